// File: rtl/servo_frame_scheduler.sv
// servo_frame_scheduler
// Owns the four servo PWM outputs and the servo frame timebase. Two requesters
// (A and B) share servo positioning through a round-robin req/grant handshake.
// An accepted update waits in a single pending slot and is copied into the
// active duty table only at the frame boundary.
//
// Ports
//   Clock, Reset          system clock, synchronous active-high reset
//   Enable                timebase runs and arbitration is active while high
//   ReqA/ServoNumA/DutyA  requester A: servo index and high-time (clocks)
//   ReqB/ServoNumB/DutyB  requester B: servo index and high-time (clocks)
//   GrantA/GrantB         1-cycle pulse: that requester's request was captured
//   PwmOut[3:0]           servo PWM pins, bit i = servo i
//   ActivePeriodFinished  1-cycle pulse the cycle after the last frame count
//   UpdatePending         captured update waiting for the frame boundary
//
// state      | meaning
// ST_IDLE    | no update held; a request may be granted
// ST_PENDING | one update captured; waiting for frame wrap to apply it
module servo_frame_scheduler #(
  parameter int unsigned FRAME_CYCLES = 2_000_000,
  parameter int unsigned DUTY_MIN     = 100_000,
  parameter int unsigned DUTY_MAX     = 200_000,
  parameter int unsigned DUTY_DEFAULT = 150_000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Enable,
  input  logic        ReqA,
  input  logic [1:0]  ServoNumA,
  input  logic [20:0] DutyA,
  input  logic        ReqB,
  input  logic [1:0]  ServoNumB,
  input  logic [20:0] DutyB,
  output logic        GrantA,
  output logic        GrantB,
  output logic [3:0]  PwmOut,
  output logic        ActivePeriodFinished,
  output logic        UpdatePending
);

  localparam int CW = 21;
  localparam logic [CW-1:0] LAST_COUNT = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] D_MIN      = CW'(DUTY_MIN);
  localparam logic [CW-1:0] D_MAX      = CW'(DUTY_MAX);
  localparam logic [CW-1:0] D_DEF      = CW'(DUTY_DEFAULT);

  typedef enum logic {ST_IDLE, ST_PENDING} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [3:0][CW-1:0]     duty_q, duty_d;
  logic [1:0]             pend_servo_q, pend_servo_d;
  logic [CW-1:0]          pend_duty_q, pend_duty_d;
  logic                   rr_b_q, rr_b_d;      // 1 = B wins the next tie
  logic                   grant_a_q, grant_a_d;
  logic                   grant_b_q, grant_b_d;
  logic [3:0]             pwm_q, pwm_d;
  logic                   apf_q, apf_d;
  logic                   pending_q, pending_d;
  logic                   wrap;
  logic                   pick_a;

  function automatic logic [CW-1:0] clamp_duty(input logic [CW-1:0] d);
    if (d < D_MIN)      return D_MIN;
    else if (d > D_MAX) return D_MAX;
    else                return d;
  endfunction

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    duty_d       = duty_q;
    pend_servo_d = pend_servo_q;
    pend_duty_d  = pend_duty_q;
    rr_b_d       = rr_b_q;
    grant_a_d    = 1'b0;
    grant_b_d    = 1'b0;
    pick_a       = 1'b0;

    wrap = Enable && (count_q == LAST_COUNT);

    if (Enable) count_d = wrap ? '0 : count_q + 1'b1;

    // PWM compares against the count of this cycle, so the pin lags by one
    // clock and is high for exactly duty clocks per frame.
    for (int i = 0; i < 4; i++) pwm_d[i] = Enable && (count_q < duty_q[i]);

    apf_d = wrap;

    case (state_q)
      ST_IDLE: begin
        if (Enable && (ReqA || ReqB)) begin
          pick_a = ReqA && (!ReqB || !rr_b_q);
          if (pick_a) begin
            grant_a_d    = 1'b1;
            pend_servo_d = ServoNumA;
            pend_duty_d  = clamp_duty(DutyA);
            rr_b_d       = 1'b1;
          end else begin
            grant_b_d    = 1'b1;
            pend_servo_d = ServoNumB;
            pend_duty_d  = clamp_duty(DutyB);
            rr_b_d       = 1'b0;
          end
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (wrap) begin
          duty_d[pend_servo_q] = pend_duty_q;
          state_d              = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pending_d = (state_d == ST_PENDING);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      duty_q       <= {4{D_DEF}};
      pend_servo_q <= '0;
      pend_duty_q  <= '0;
      rr_b_q       <= 1'b0;
      grant_a_q    <= 1'b0;
      grant_b_q    <= 1'b0;
      pwm_q        <= '0;
      apf_q        <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      duty_q       <= duty_d;
      pend_servo_q <= pend_servo_d;
      pend_duty_q  <= pend_duty_d;
      rr_b_q       <= rr_b_d;
      grant_a_q    <= grant_a_d;
      grant_b_q    <= grant_b_d;
      pwm_q        <= pwm_d;
      apf_q        <= apf_d;
      pending_q    <= pending_d;
    end
  end

  assign GrantA               = grant_a_q;
  assign GrantB               = grant_b_q;
  assign PwmOut               = pwm_q;
  assign ActivePeriodFinished = apf_q;
  assign UpdatePending        = pending_q;

endmodule

// File: tb/tb_servo_frame_scheduler.sv
// tb_servo_frame_scheduler
// Randomized and directed stimulus for servo_frame_scheduler. A reference
// model tracks frame position, the per-servo duty table, the single pending
// update and the round-robin preference; PWM is checked as total high-time
// per frame, measured between ActivePeriodFinished pulses.
module tb_servo_frame_scheduler;

  localparam int F     = 1000;
  localparam int DMIN  = 100;
  localparam int DMAX  = 200;
  localparam int DDEF  = 150;

  logic        Clock, Reset, Enable;
  logic        ReqA, ReqB;
  logic [1:0]  ServoNumA, ServoNumB;
  logic [20:0] DutyA, DutyB;
  logic        GrantA, GrantB;
  logic [3:0]  PwmOut;
  logic        ActivePeriodFinished, UpdatePending;

  servo_frame_scheduler #(
    .FRAME_CYCLES(F), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX), .DUTY_DEFAULT(DDEF)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable),
    .ReqA(ReqA), .ServoNumA(ServoNumA), .DutyA(DutyA),
    .ReqB(ReqB), .ServoNumB(ServoNumB), .DutyB(DutyB),
    .GrantA(GrantA), .GrantB(GrantB), .PwmOut(PwmOut),
    .ActivePeriodFinished(ActivePeriodFinished), .UpdatePending(UpdatePending)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  function automatic int clamp(input int d);
    if (d < DMIN) return DMIN;
    if (d > DMAX) return DMAX;
    return d;
  endfunction

  // reference model state
  int pos_m = 0;
  int duty_m [4] = '{DDEF, DDEF, DDEF, DDEF};
  int hi_cnt [4] = '{0, 0, 0, 0};
  bit pend_m = 0;
  int ps_m = 0, pd_m = 0;
  bit pref_b = 0;
  // inputs as seen during the previous cycle
  bit rst_p = 1, en_p = 0, ra_p = 0, rb_p = 0;
  int sa_p = 0, sb_p = 0, da_p = 0, db_p = 0;

  always @(negedge Clock) begin
    bit e_apf, e_ga, e_gb;
    e_apf = !rst_p && en_p && (pos_m == F - 1);
    e_ga = 0;
    e_gb = 0;
    if (!rst_p && en_p && !pend_m) begin
      if (ra_p && rb_p) begin
        if (pref_b) e_gb = 1; else e_ga = 1;
      end else if (ra_p) e_ga = 1;
      else if (rb_p) e_gb = 1;
    end
    check_eq("frame_pulse", 32'(ActivePeriodFinished), 32'(e_apf));
    check_eq("grant_a", 32'(GrantA), 32'(e_ga));
    check_eq("grant_b", 32'(GrantB), 32'(e_gb));
    if (rst_p || !en_p) check_eq("pwm_idle", 32'(PwmOut), 32'd0);

    if (rst_p) begin
      pos_m = 0;
      pend_m = 0;
      pref_b = 0;
      for (int i = 0; i < 4; i++) begin
        duty_m[i] = DDEF;
        hi_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) hi_cnt[i] += int'(PwmOut[i]);
      if (e_apf) begin
        for (int i = 0; i < 4; i++) begin
          check_eq($sformatf("high_time_s%0d", i), 32'(hi_cnt[i]), 32'(duty_m[i]));
          hi_cnt[i] = 0;
        end
        if (pend_m) duty_m[ps_m] = pd_m;
        pend_m = 0;
      end
      if (e_ga) begin
        pend_m = 1; ps_m = sa_p; pd_m = clamp(da_p); pref_b = 1;
      end else if (e_gb) begin
        pend_m = 1; ps_m = sb_p; pd_m = clamp(db_p); pref_b = 0;
      end
      if (en_p) pos_m = (pos_m == F - 1) ? 0 : pos_m + 1;
    end
    check_eq("update_pending", 32'(UpdatePending), 32'(pend_m));

    rst_p = Reset; en_p = Enable;
    ra_p = ReqA; rb_p = ReqB;
    sa_p = int'(ServoNumA); sb_p = int'(ServoNumB);
    da_p = int'(DutyA); db_p = int'(DutyB);
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic do_req_a(input logic [1:0] s, input logic [20:0] d);
    bit got = 0;
    ReqA = 1'b1; ServoNumA = s; DutyA = d;
    for (int k = 0; k < 3 * F + 10 && !got; k++) begin
      step(1);
      got = GrantA;
    end
    ReqA = 1'b0;
    check_eq("grant_a_wait", 32'(got), 32'd1);
  endtask

  task automatic do_req_b(input logic [1:0] s, input logic [20:0] d);
    bit got = 0;
    ReqB = 1'b1; ServoNumB = s; DutyB = d;
    for (int k = 0; k < 3 * F + 10 && !got; k++) begin
      step(1);
      got = GrantB;
    end
    ReqB = 1'b0;
    check_eq("grant_b_wait", 32'(got), 32'd1);
  endtask

  initial begin
    logic [1:0]  s_a, s_b;
    logic [20:0] d_a, d_b;
    Reset = 1'b1; Enable = 1'b0;
    ReqA = 1'b0; ServoNumA = '0; DutyA = '0;
    ReqB = 1'b0; ServoNumB = '0; DutyB = '0;
    step(3);
    Reset = 1'b0; Enable = 1'b1;
    step(2200);

    step(137);
    do_req_a(2'd1, 21'd180);
    step(2100);

    repeat (2) begin
      s_a = 2'($urandom_range(0, 3)); d_a = 21'($urandom_range(100, 200));
      s_b = 2'($urandom_range(0, 3)); d_b = 21'($urandom_range(100, 200));
      fork
        do_req_a(s_a, d_a);
        do_req_b(s_b, d_b);
      join
    end
    step(1100);

    do_req_b(2'd3, 21'd50);
    step(2100);
    do_req_b(2'd3, 21'd250);
    step(2100);

    do_req_a(2'd2, 21'd130);
    step(100);
    Enable = 1'b0;
    step(300);
    Enable = 1'b1;
    step(2100);

    do_req_b(2'd0, 21'd190);
    step(50);
    Reset = 1'b1;
    step(2);
    Reset = 1'b0;
    step(2100);

    for (int c = 0; c < 20000; c++) begin
      if (ReqA) begin
        if (GrantA || $urandom_range(0, 399) == 0) ReqA = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        ReqA = 1'b1; ServoNumA = 2'($urandom_range(0, 3)); DutyA = 21'($urandom_range(0, 300));
      end
      if (ReqB) begin
        if (GrantB || $urandom_range(0, 399) == 0) ReqB = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        ReqB = 1'b1; ServoNumB = 2'($urandom_range(0, 3)); DutyB = 21'($urandom_range(0, 300));
      end
      if ($urandom_range(0, 2999) == 0) Enable = !Enable;
      Reset = ($urandom_range(0, 7999) == 0);
      step(1);
    end
    Reset = 1'b0; Enable = 1'b1; ReqA = 1'b0; ReqB = 1'b0;
    step(2100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
